oldland_exec_mdu: RTL and testbench

- Parametrised iterative multiply/divide unit attached to the execute stage, alongside the single-cycle ALU.
- Executes unsigned multiply (low or high word) and unsigned divide/remainder over UNROLL bits per cycle.
- Asserts busy so the pipeline holds while it runs.
- Returns the result with a one-cycle done pulse and a destination register tag for writeback.

---
 rtl/oldland_exec_mdu_pkg.sv | 25 ++
 rtl/oldland_mdu_step.sv | 37 +++
 rtl/oldland_exec_mdu.sv | 139 +++++++++++++
 tb/tb_oldland_exec_mdu.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/oldland_exec_mdu_pkg.sv
// Shared encodings for the iterative multiply/divide unit.
// Opcode values sit alongside the ALU opcode space used by the execute stage.
package oldland_exec_mdu_pkg;

    localparam logic [1:0] MDU_OP_MUL   = 2'd0;
    localparam logic [1:0] MDU_OP_MULHU = 2'd1;
    localparam logic [1:0] MDU_OP_DIVU  = 2'd2;
    localparam logic [1:0] MDU_OP_REMU  = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } mdu_state_t;

    function automatic logic op_is_div(input logic [1:0] op);
        return (op == MDU_OP_DIVU) || (op == MDU_OP_REMU);
    endfunction

    // MULHU and REMU both take their answer from the upper datapath half.
    function automatic logic op_hi_word(input logic [1:0] op);
        return !((op == MDU_OP_MUL) || (op == MDU_OP_DIVU));
    endfunction

endpackage

// File: rtl/oldland_mdu_step.sv
// One combinational bit-step of the shared multiply/divide datapath.
// hi/lo form a double-width register: product for multiply, remainder:quotient for divide.
module oldland_mdu_step #(
    parameter int WIDTH = 32
) (
    input  logic             i_div,
    input  logic [WIDTH-1:0] i_hi,
    input  logic [WIDTH-1:0] i_lo,
    input  logic [WIDTH-1:0] i_m,
    output logic [WIDTH-1:0] o_hi,
    output logic [WIDTH-1:0] o_lo
);

    logic [WIDTH:0] w_sum;
    logic [WIDTH:0] w_trial;
    logic [WIDTH:0] w_diff;

    assign w_sum   = {1'b0, i_hi} + (i_lo[0] ? {1'b0, i_m} : '0);
    assign w_trial = {i_hi, i_lo[WIDTH-1]};
    // Partial remainder stays below the divisor, so the top diff bit is a clean borrow.
    assign w_diff  = w_trial - {1'b0, i_m};

    always_comb begin
        o_hi = w_sum[WIDTH:1];
        o_lo = {w_sum[0], i_lo[WIDTH-1:1]};
        if (i_div) begin
            if (w_diff[WIDTH]) begin
                o_hi = w_trial[WIDTH-1:0];
                o_lo = {i_lo[WIDTH-2:0], 1'b0};
            end else begin
                o_hi = w_diff[WIDTH-1:0];
                o_lo = {i_lo[WIDTH-2:0], 1'b1};
            end
        end
    end

endmodule

// File: rtl/oldland_exec_mdu.sv
// Iterative unsigned multiply/divide unit for the execute stage.
// Retires UNROLL bits per RUN cycle and reports completion with a one-cycle done pulse.
module oldland_exec_mdu #(
    parameter int WIDTH    = 32,
    parameter int UNROLL   = 1,
    parameter int TAG_BITS = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic [1:0]          op,
    input  logic [WIDTH-1:0]    a,
    input  logic [WIDTH-1:0]    b,
    input  logic [TAG_BITS-1:0] rd_sel,
    input  logic                abort,
    output logic                busy,
    output logic                done,
    output logic [WIDTH-1:0]    result,
    output logic                result_z,
    output logic [TAG_BITS-1:0] rd_sel_out,
    output logic                div_by_zero
);
    import oldland_exec_mdu_pkg::*;

    localparam int STEPS = WIDTH / UNROLL;
    localparam int CNT_W = $clog2(STEPS) + 1;

    mdu_state_t          r_state;
    mdu_state_t          w_next;
    logic [CNT_W-1:0]    r_cnt;
    logic [WIDTH-1:0]    r_hi;
    logic [WIDTH-1:0]    r_lo;
    logic [WIDTH-1:0]    r_m;
    logic [1:0]          r_op;
    logic [TAG_BITS-1:0] r_tag;
    logic [WIDTH-1:0]    r_result;
    logic                r_result_z;
    logic [TAG_BITS-1:0] r_rd_sel_out;
    logic                r_dz;

    logic                w_accept;
    logic                w_div0;
    logic                w_last;
    logic                w_div_mode;
    logic [WIDTH-1:0]    w_div0_res;
    logic [WIDTH-1:0]    w_final;
    logic [WIDTH-1:0]    w_hi [0:UNROLL];
    logic [WIDTH-1:0]    w_lo [0:UNROLL];

    // Abort outranks start, and start is only honoured while not running.
    assign w_accept   = start && !abort && (r_state != ST_RUN);
    assign w_div0     = op_is_div(op) && (b == '0);
    assign w_div0_res = op_hi_word(op) ? a : '1;
    assign w_last     = (r_state == ST_RUN) && !abort && (r_cnt == CNT_W'(1));
    assign w_div_mode = op_is_div(r_op);

    assign w_hi[0] = r_hi;
    assign w_lo[0] = r_lo;
    for (genvar g = 0; g < UNROLL; g++) begin : g_step
        oldland_mdu_step #(.WIDTH(WIDTH)) u_step (
            .i_div (w_div_mode),
            .i_hi  (w_hi[g]),
            .i_lo  (w_lo[g]),
            .i_m   (r_m),
            .o_hi  (w_hi[g+1]),
            .o_lo  (w_lo[g+1])
        );
    end
    assign w_final = op_hi_word(r_op) ? w_hi[UNROLL] : w_lo[UNROLL];

    always_ff @(posedge clk) begin
        if (rst) r_state <= ST_IDLE;
        else     r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE, ST_DONE: begin
                w_next = ST_IDLE;
                if (w_accept) w_next = w_div0 ? ST_DONE : ST_RUN;
            end
            ST_RUN: begin
                if (abort)                     w_next = ST_IDLE;
                else if (r_cnt == CNT_W'(1))   w_next = ST_DONE;
            end
            default: w_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt        <= '0;
            r_result     <= '0;
            r_result_z   <= 1'b1;
            r_rd_sel_out <= '0;
            r_dz         <= 1'b0;
        end else if (w_accept) begin
            r_dz <= w_div0;
            if (w_div0) begin
                r_cnt        <= '0;
                r_result     <= w_div0_res;
                r_result_z   <= (w_div0_res == '0);
                r_rd_sel_out <= rd_sel;
            end else begin
                r_cnt <= CNT_W'(STEPS);
            end
        end else if (r_state == ST_RUN) begin
            r_cnt <= abort ? '0 : r_cnt - CNT_W'(1);
            if (w_last) begin
                r_result     <= w_final;
                r_result_z   <= (w_final == '0);
                r_rd_sel_out <= r_tag;
            end
        end
    end

    // Operand/datapath registers carry no reset; they are always loaded on accept.
    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_op  <= op;
            r_tag <= rd_sel;
            r_m   <= op_is_div(op) ? b : a;
            r_hi  <= '0;
            r_lo  <= op_is_div(op) ? a : b;
        end else if (r_state == ST_RUN) begin
            r_hi <= w_hi[UNROLL];
            r_lo <= w_lo[UNROLL];
        end
    end

    assign busy        = (r_state == ST_RUN);
    assign done        = (r_state == ST_DONE);
    assign result      = r_result;
    assign result_z    = r_result_z;
    assign rd_sel_out  = r_rd_sel_out;
    assign div_by_zero = r_dz;

endmodule

// File: tb/tb_oldland_exec_mdu.sv
// Bench for oldland_exec_mdu: UNROLL=1 and UNROLL=4 instances share one stimulus stream
// and are compared every cycle against a cycle-count/arithmetic reference model.
module tb_oldland_exec_mdu;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        st  = 1'b0;
    logic        ab  = 1'b0;
    logic [1:0]  o   = 2'd0;
    logic [31:0] x   = '0;
    logic [31:0] y   = '0;
    logic [3:0]  t   = '0;

    logic        u1_busy, u1_done, u1_z, u1_dz;
    logic [31:0] u1_res;
    logic [3:0]  u1_tag;
    logic        u4_busy, u4_done, u4_z, u4_dz;
    logic [31:0] u4_res;
    logic [3:0]  u4_tag;

    int errs = 0;
    int chks = 0;

    always #5 clk = ~clk;

    oldland_exec_mdu #(.WIDTH(32), .UNROLL(1), .TAG_BITS(4)) u_dut1 (
        .clk(clk), .rst(rst), .start(st), .op(o), .a(x), .b(y), .rd_sel(t), .abort(ab),
        .busy(u1_busy), .done(u1_done), .result(u1_res), .result_z(u1_z),
        .rd_sel_out(u1_tag), .div_by_zero(u1_dz)
    );

    oldland_exec_mdu #(.WIDTH(32), .UNROLL(4), .TAG_BITS(4)) u_dut4 (
        .clk(clk), .rst(rst), .start(st), .op(o), .a(x), .b(y), .rd_sel(t), .abort(ab),
        .busy(u4_busy), .done(u4_done), .result(u4_res), .result_z(u4_z),
        .rd_sel_out(u4_tag), .div_by_zero(u4_dz)
    );

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        chks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Reference model: an accepted op completes at a known cycle with a known answer.
    typedef struct {
        bit          valid;
        bit          inflight;
        int          done_at;
        logic [31:0] res, pres;
        logic        z, pz, dz, pdz;
        logic [3:0]  tag, ptag;
    } mdl_t;

    mdl_t m1, m4;
    int   mc = 0;

    function automatic mdl_t mstep(input mdl_t m, input int c, input int lat, input bit r,
                                   input bit s, input bit abt, input logic [1:0] op_,
                                   input logic [31:0] a_, input logic [31:0] b_,
                                   input logic [3:0] t_);
        mdl_t        n;
        bit          bsy;
        logic [63:0] p;
        n   = m;
        bsy = m.inflight && (c < m.done_at);
        if (r) begin
            n.valid = 1; n.inflight = 0; n.done_at = -10;
            n.res = '0; n.z = 1; n.tag = '0; n.dz = 0;
            return n;
        end
        if (bsy && abt) begin
            n.inflight = 0;
        end else if (!bsy && s && !abt) begin
            p = {32'd0, a_} * {32'd0, b_};
            case (op_)
                2'd0: n.pres = p[31:0];
                2'd1: n.pres = p[63:32];
                2'd2: if (b_ == 0) n.pres = 32'hFFFF_FFFF; else n.pres = a_ / b_;
                default: if (b_ == 0) n.pres = a_; else n.pres = a_ % b_;
            endcase
            n.pdz      = op_[1] && (b_ == 0);
            n.pz       = (n.pres == 0);
            n.ptag     = t_;
            n.dz       = 0;
            n.inflight = 1;
            n.done_at  = c + 1 + (n.pdz ? 0 : lat);
        end
        if (n.inflight && n.done_at == c + 1) begin
            n.res = n.pres; n.z = n.pz; n.tag = n.ptag; n.dz = n.pdz;
        end
        return n;
    endfunction

    task automatic cmp(input string p, input mdl_t m, input int c, input logic bsy,
                       input logic dn, input logic [31:0] res, input logic z,
                       input logic [3:0] tg, input logic dz);
        chk({p, "_busy"},   bsy, m.inflight && (c < m.done_at));
        chk({p, "_done"},   dn,  m.inflight && (c == m.done_at));
        chk({p, "_result"}, res, m.res);
        chk({p, "_zero"},   z,   m.z);
        chk({p, "_tag"},    tg,  m.tag);
        chk({p, "_dz"},     dz,  m.dz);
    endtask

    always @(negedge clk) begin
        if (m1.valid) cmp("u1", m1, mc, u1_busy, u1_done, u1_res, u1_z, u1_tag, u1_dz);
        if (m4.valid) cmp("u4", m4, mc, u4_busy, u4_done, u4_res, u4_z, u4_tag, u4_dz);
        m1 = mstep(m1, mc, 32, rst, st, ab, o, x, y, t);
        m4 = mstep(m4, mc, 8,  rst, st, ab, o, x, y, t);
        mc++;
    end

    task automatic wait_idle();
        int g = 0;
        do begin
            @(posedge clk); #1;
            g++;
        end while ((u1_busy !== 1'b0 || u4_busy !== 1'b0) && g < 200);
        if (g >= 200) begin
            chks++; errs++;
            $display("FAIL idle_wait: busy1=%b busy4=%b after %0d cycles", u1_busy, u4_busy, g);
        end
    endtask

    // Issue one op on both instances; start is held during cycle 0, done cycles measured from it.
    task automatic run_op(input string nm, input logic [1:0] op_, input logic [31:0] a_,
                          input logic [31:0] b_, input logic [3:0] t_, input logic [31:0] er,
                          input int l1, input int l4, input logic edz);
        int k, k1, k4;
        logic [31:0] r1v, r4v;
        logic z1v, dz1v, dz4v;
        logic [3:0] t1v;
        wait_idle();
        o = op_; x = a_; y = b_; t = t_; st = 1;
        @(posedge clk); #1 st = 0;
        k = 1; k1 = -1; k4 = -1;
        r1v = '0; r4v = '0; z1v = 0; dz1v = 0; dz4v = 0; t1v = '0;
        while ((k1 < 0 || k4 < 0) && k < 200) begin
            @(negedge clk);
            if (k1 < 0 && u1_done === 1'b1) begin
                k1 = k; r1v = u1_res; z1v = u1_z; dz1v = u1_dz; t1v = u1_tag;
            end
            if (k4 < 0 && u4_done === 1'b1) begin
                k4 = k; r4v = u4_res; dz4v = u4_dz;
            end
            k++;
        end
        chk({nm, "_lat1"}, k1, l1);
        chk({nm, "_lat4"}, k4, l4);
        chk({nm, "_res1"}, r1v, er);
        chk({nm, "_res4"}, r4v, er);
        chk({nm, "_z1"},   z1v, er == 0);
        chk({nm, "_dz1"},  dz1v, edz);
        chk({nm, "_dz4"},  dz4v, edz);
        chk({nm, "_tag1"}, t1v, t_);
    endtask

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 5))
            0:       return 32'd0;
            1:       return 32'hFFFF_FFFF;
            2:       return 32'($urandom_range(0, 15));
            default: return $urandom;
        endcase
    endfunction

    initial begin
        int g;
        bit seen;
        repeat (3) @(posedge clk);
        #1 rst = 0;
        @(posedge clk); #1;
        chk("reset_result", u1_res, 32'd0);
        chk("reset_zero", u1_z, 1'b1);

        run_op("mul7x6",   2'd0, 32'd7, 32'd6, 4'd5, 32'd42, 33, 9, 1'b0);
        run_op("mulhu_ff", 2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 4'd1, 32'hFFFF_FFFE, 33, 9, 1'b0);
        run_op("mul_ff",   2'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 4'd2, 32'h0000_0001, 33, 9, 1'b0);
        run_op("divu100",  2'd2, 32'd100, 32'd7, 4'd3, 32'd14, 33, 9, 1'b0);
        run_op("remu100",  2'd3, 32'd100, 32'd7, 4'd4, 32'd2, 33, 9, 1'b0);
        run_op("divu_z",   2'd2, 32'd5, 32'd0, 4'd6, 32'hFFFF_FFFF, 1, 1, 1'b1);
        run_op("remu_z",   2'd3, 32'd5, 32'd0, 4'd7, 32'd5, 1, 1, 1'b1);
        run_op("mul0",     2'd0, 32'd0, 32'd5, 4'd8, 32'd0, 33, 9, 1'b0);
        run_op("mul3x4",   2'd0, 32'd3, 32'd4, 4'd9, 32'd12, 33, 9, 1'b0);
        run_op("div8000",  2'd2, 32'h8000_0000, 32'd3, 4'd10, 32'h2AAA_AAAA, 33, 9, 1'b0);

        // Back-to-back: restart the UNROLL=4 unit in its DONE cycle while UNROLL=1 is still running.
        wait_idle();
        o = 2'd2; x = 32'h8000_0000; y = 32'd3; t = 4'd2; st = 1;
        @(posedge clk); #1 st = 0;
        g = 1;
        while (u4_done !== 1'b1 && g < 50) begin @(posedge clk); #1; g++; end
        chk("b2b_first_lat", g, 9);
        chk("b2b_first_res", u4_res, 32'h2AAA_AAAA);
        o = 2'd0; x = 32'd3; y = 32'd4; t = 4'd9; st = 1;
        @(posedge clk); #1 st = 0;
        g = 1;
        while (u4_done !== 1'b1 && g < 50) begin @(posedge clk); #1; g++; end
        chk("b2b_second_lat", g, 9);
        chk("b2b_second_res", u4_res, 32'd12);
        wait_idle();
        chk("busy_start_ignored", u1_res, 32'h2AAA_AAAA);

        // Abort mid-divide, with a start pulse while busy beforehand.
        o = 2'd2; x = 32'd1000; y = 32'd10; t = 4'd3; st = 1;
        @(posedge clk); #1 st = 0;
        repeat (4) begin @(posedge clk); #1; end
        o = 2'd0; x = 32'd1; y = 32'd1; st = 1;
        @(posedge clk); #1 st = 0;
        repeat (4) begin @(posedge clk); #1; end
        ab = 1;
        @(posedge clk); #1 ab = 0;
        chk("abort_busy", u1_busy, 1'b0);
        chk("abort_res", u1_res, 32'h2AAA_AAAA);
        seen = 0;
        repeat (40) begin @(negedge clk); if (u1_done === 1'b1) seen = 1; end
        chk("abort_no_done", seen, 1'b0);

        // Reset in the middle of a multiply.
        wait_idle();
        o = 2'd0; x = 32'd7; y = 32'd6; t = 4'd5; st = 1;
        @(posedge clk); #1 st = 0;
        repeat (4) begin @(posedge clk); #1; end
        rst = 1;
        @(posedge clk); #1 rst = 0;
        chk("rst_busy", u1_busy, 1'b0);
        chk("rst_done", u1_done, 1'b0);
        chk("rst_res", u1_res, 32'd0);
        chk("rst_zero", u1_z, 1'b1);
        chk("rst_tag", u1_tag, 4'd0);

        // Random traffic, checked by the per-cycle model.
        repeat (3000) begin
            st  = ($urandom_range(0, 2) == 0);
            ab  = ($urandom_range(0, 19) == 0);
            rst = ($urandom_range(0, 399) == 0);
            o   = 2'($urandom_range(0, 3));
            x   = pick();
            y   = pick();
            t   = 4'($urandom);
            @(posedge clk); #1;
        end
        st = 0; ab = 0; rst = 0;
        repeat (50) @(posedge clk);
        @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errs, chks);
        $finish;
    end

endmodule
